fdiv_seq: RTL

FDIV_SEQ -- requirements
Module: fdiv_seq

---
 rtl/fdiv_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single-precision divider wrapper around an iterative mantissa core.
// Operands are classified, then specials are packed directly or the core is run, normalised and rounded.
module fdiv_seq #(
    parameter int Q_LAT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  flags,
    output logic [23:0] core_a,
    output logic [23:0] core_b,
    output logic        core_fdiv,
    output logic        core_ena,
    input  logic [31:0] core_q,
    input  logic        core_busy,
    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and result/flags stay stable while out_valid is high.

    localparam int CW = (Q_LAT > 1) ? $clog2(Q_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAITB = 3'd2,
        DRAIN = 3'd3,
        PACK  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nx;

    logic              spec_r;
    logic [31:0]       sres_r;
    logic [4:0]        sflg_r;
    logic              sgn_r;
    logic signed [9:0] exp_r;
    logic [31:0]       q_r;
    logic              seen_busy;
    logic [CW-1:0]     cnt;

    // Operand classification (subnormals count as zero)
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sgn, cls_special;
    logic [31:0] cls_res;
    logic [4:0]  cls_flg;
    logic signed [9:0] e_in;

    assign a_nan  = (&a[30:23]) & (|a[22:0]);
    assign a_inf  = (&a[30:23]) & ~(|a[22:0]);
    assign a_zero = ~(|a[30:23]);
    assign b_nan  = (&b[30:23]) & (|b[22:0]);
    assign b_inf  = (&b[30:23]) & ~(|b[22:0]);
    assign b_zero = ~(|b[30:23]);
    assign sgn    = a[31] ^ b[31];
    assign cls_special = a_nan | a_inf | a_zero | b_nan | b_inf | b_zero;
    assign e_in = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;

    always_comb begin
        cls_res = {sgn, 31'd0};
        cls_flg = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            cls_res = 32'h7FC0_0000;
            cls_flg = 5'b10000;
        end else if (a_inf) begin
            cls_res = {sgn, 8'hFF, 23'd0};
        end else if (b_zero) begin
            cls_res = {sgn, 8'hFF, 23'd0};
            cls_flg = 5'b01000;
        end
    end

    // Normalise, round-to-nearest-even, range check
    logic [23:0]       mant;
    logic              grd, stk, rnd, inx;
    logic [24:0]       mant_sum;
    logic [23:0]       mant_f;
    logic signed [9:0] e_n, e_f;
    logic [31:0]       norm_res;
    logic [4:0]        norm_flg;

    always_comb begin
        if (q_r[31]) begin
            mant = q_r[31:8];
            grd  = q_r[7];
            stk  = |q_r[6:0];
            e_n  = exp_r;
        end else begin
            mant = q_r[30:7];
            grd  = q_r[6];
            stk  = |q_r[5:0];
            e_n  = exp_r - 10'sd1;
        end
        rnd      = grd & (stk | mant[0]);
        inx      = grd | stk;
        mant_sum = {1'b0, mant} + {24'd0, rnd};
        if (mant_sum[24]) begin
            mant_f = 24'h80_0000;
            e_f    = e_n + 10'sd1;
        end else begin
            mant_f = mant_sum[23:0];
            e_f    = e_n;
        end
        if (e_f >= 10'sd255) begin
            norm_res = {sgn_r, 8'hFF, 23'd0};
            norm_flg = 5'b00101;
        end else if (e_f <= 10'sd0) begin
            norm_res = {sgn_r, 31'd0};
            norm_flg = 5'b00011;
        end else begin
            norm_res = {sgn_r, e_f[7:0], mant_f[22:0]};
            norm_flg = {4'b0000, inx};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_nx = cls_special ? PACK : ISSUE;
            ISSUE:   state_nx = WAITB;
            WAITB:   if (seen_busy && !core_busy) state_nx = DRAIN;
            DRAIN:   if (cnt == CW'(Q_LAT - 1)) state_nx = PACK;
            PACK:    state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            spec_r    <= 1'b0;
            sres_r    <= 32'd0;
            sflg_r    <= 5'd0;
            sgn_r     <= 1'b0;
            exp_r     <= 10'sd0;
            q_r       <= 32'd0;
            seen_busy <= 1'b0;
            cnt       <= '0;
            core_a    <= 24'd0;
            core_b    <= 24'd0;
            result    <= 32'd0;
            flags     <= 5'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        spec_r <= cls_special;
                        sres_r <= cls_res;
                        sflg_r <= cls_flg;
                        sgn_r  <= sgn;
                        exp_r  <= e_in;
                        if (!cls_special) begin
                            core_a <= {1'b1, a[22:0]};
                            core_b <= {1'b1, b[22:0]};
                        end
                    end
                end
                ISSUE: seen_busy <= 1'b0;
                WAITB: if (core_busy) seen_busy <= 1'b1;
                DRAIN: begin
                    if (cnt == CW'(Q_LAT - 1)) begin
                        q_r <= core_q;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PACK: begin
                    result <= spec_r ? sres_r : norm_res;
                    flags  <= spec_r ? sflg_r : norm_flg;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = rstn && (state == IDLE);
    assign out_valid = (state == DONE);
    assign core_fdiv = (state == ISSUE);
    assign core_ena  = (state == ISSUE) || (state == WAITB) || (state == DRAIN);
    assign dbg_state = state;

endmodule
